button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Front-end conditioner for a raw mechanical push-button (PMOD/board pin).
//  Synchronises the asynchronous pin, rejects contact bounce, and emits a clean
//  level plus single-cycle press/release/auto-repeat pulses in the clk domain.
//  Sits directly upstream of the LED counter/divider stages, which consume
//  press_pulse / hold_pulse as count enables instead of using the pin as a clock.
// PARAMETERS
//  ACTIVE_LOW       1        1: pin reads 0 when pressed (pull-up); 0: pin reads 1 when pressed
//  DEBOUNCE_CYCLES  120000   consecutive stable clk cycles required to accept a change (10 ms @ 12 MHz)
//  HOLD_CYCLES      6000000  cycles held after accepted press before first hold_pulse (0.5 s)
//  REPEAT_CYCLES    1200000  cycles between subsequent hold_pulses while held (100 ms)
//  REPEAT_EN        1        0: hold/repeat disabled, hold_pulse constantly 0
//  All cycle parameters >= 2; counter widths derived with $clog2.
// PORTS
//  clk            input   1  system clock (12 MHz)
//  rst            input   1  reset, asynchronous, active-high
//  btn_raw        input   1  raw asynchronous button pin
//  btn_level      output  1  debounced state, 1 = pressed
//  press_pulse    output  1  one-cycle strobe on accepted press
//  release_pulse  output  1  one-cycle strobe on accepted release
//  hold_pulse     output  1  one-cycle strobe: first after HOLD_CYCLES, then every REPEAT_CYCLES
// BEHAVIOUR
//  - Reset: clock is clk; reset is rst, asynchronous, active-high. All outputs 0, state IDLE,
//    counters 0, both sync flops loaded with the released pin level.
//  - Sync: 2-flop synchroniser; pressed = ACTIVE_LOW ? ~sync : sync. FSM uses only pressed.
//  - All outputs registered; pulses exactly 1 cycle wide; never two pulses in same cycle.
//  - FSM states / transitions (evaluated each posedge clk):
//    IDLE:         pressed -> PRESS_WAIT, cnt=0.
//    PRESS_WAIT:   !pressed -> IDLE (bounce, no output). cnt==DEBOUNCE_CYCLES-1 -> PRESSED,
//                  press_pulse=1, btn_level=1, hold_cnt=0. else cnt++.
//    PRESSED:      !pressed -> RELEASE_WAIT, cnt=0. REPEAT_EN && hold_cnt==HOLD_CYCLES-1 -> REPEAT,
//                  hold_pulse=1, rep_cnt=0. else hold_cnt++ (saturates if REPEAT_EN=0).
//    REPEAT:       !pressed -> RELEASE_WAIT, cnt=0. rep_cnt==REPEAT_CYCLES-1 -> hold_pulse=1,
//                  rep_cnt=0. else rep_cnt++.
//    RELEASE_WAIT: pressed -> PRESSED, hold_cnt=0 (hold timing restarts, no pulse).
//                  cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1, btn_level=0. else cnt++.
//  - btn_level stays 1 through RELEASE_WAIT; stays 0 through PRESS_WAIT.
//  - Latency (bounce-free): press_pulse asserted after clock edge E+DEBOUNCE_CYCLES+2, where E is
//    the first edge sampling btn_raw pressed; release_pulse same latency from release.
//    First hold_pulse HOLD_CYCLES edges after press_pulse; then every REPEAT_CYCLES edges.
//  - Any bounce shorter than DEBOUNCE_CYCLES produces no output change.
//  - Reset mid-press: outputs drop to 0 immediately; if button still held after rst deasserts,
//    a full debounce runs and a fresh press_pulse is produced. No release_pulse for the reset.
//  - Counters never wrap: each is cleared on state entry and compared against terminal value.
// TESTING  (bench params: ACTIVE_LOW=1, DEBOUNCE=4, HOLD=10, REPEAT=3; edge 0 = first pressed sample)
//  1. Hold rst with btn_raw=1 -> all outputs 0; release rst, idle 20 cycles -> outputs remain 0.
//  2. btn_raw=0 for 12 cycles then 1 -> press_pulse high after edge 6 only, btn_level=1 edges 6..,
//     release_pulse exactly one cycle 6 edges after release, btn_level=0 from then.
//  3. Press bounce: btn_raw 0 for 3 cycles, 1 for 2, repeated x5, then 1 -> zero pulses, btn_level=0.
//  4. Hold btn_raw=0 for 30 cycles -> press_pulse @6, hold_pulse @16,19,22,25,28..., btn_level=1.
//  5. Release bounce: after accepted press, 1 for 2 cycles then 0 -> no release_pulse, btn_level=1,
//     hold_pulse re-times 10 edges after return to pressed.
//  6. Assert rst at edge 18 while held, release at 20 with btn_raw=0 -> outputs 0 during reset,
//     new press_pulse 6 edges after first post-reset sample; no release_pulse emitted.

Source files
------------

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions a raw mechanical push-button pin for use inside the clk domain.
// The pin is brought in through a two-flop synchroniser, then a small FSM
// requires the synchronised level to stay stable for DEBOUNCE_CYCLES before a
// press or release is accepted. Accepted changes are reported as a clean
// level plus single-cycle strobes. While the button is held, an optional
// auto-repeat strobe fires first after HOLD_CYCLES and then every
// REPEAT_CYCLES. Downstream stages use these strobes as count enables, so
// every output is a flop and at most one strobe is high in any cycle.
//
// Parameters
//   ACTIVE_LOW       1: pin reads 0 when pressed (pull-up), 0: pin reads 1
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (>= 2)
//   HOLD_CYCLES      cycles after an accepted press before the first
//                    hold_pulse (>= 2)
//   REPEAT_CYCLES    cycles between later hold_pulses (>= 2)
//   REPEAT_EN        0 disables hold/repeat; hold_pulse then stays 0
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active high
//   btn_raw        in   raw asynchronous button pin
//   btn_level      out  debounced state, 1 = pressed
//   press_pulse    out  one-cycle strobe on an accepted press
//   release_pulse  out  one-cycle strobe on an accepted release
//   hold_pulse     out  one-cycle auto-repeat strobe while held
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned HOLD_CYCLES     = 6000000,
    parameter int unsigned REPEAT_CYCLES   = 1200000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    // Each counter only has to reach its terminal value (N-1).
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HLD_W = $clog2(HOLD_CYCLES);
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    // Pin level that means "not pressed"; the synchroniser resets to it so
    // leaving reset never looks like a press edge.
    localparam logic PIN_RELEASED = ACTIVE_LOW;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    logic             sync_meta;
    logic             sync_out;
    logic             pressed;
    logic [DB_W-1:0]  cnt;       // debounce timer, shared by both wait states
    logic [HLD_W-1:0] hold_cnt;  // time held since the accepted press
    logic [REP_W-1:0] rep_cnt;   // time since the last hold_pulse

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous pin.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= PIN_RELEASED;
            sync_out  <= PIN_RELEASED;
        end else begin
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
        end
    end

    // Polarity is folded in here so the FSM only ever sees "pressed".
    assign pressed = ACTIVE_LOW ? ~sync_out : sync_out;

    // -------------------------------------------------------------------------
    // Debounce / hold / repeat FSM. The strobes default low every cycle, so
    // each one is exactly one cycle wide. Every state drives at most one
    // strobe, so two strobes can never coincide.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;

            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                // btn_level stays 0 here; a short glitch just falls back.
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end

                // With repeat disabled, hold_cnt parks at its terminal value
                // instead of wrapping.
                PRESSED: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (REPEAT_EN && (hold_cnt == HLD_LAST)) begin
                        state      <= REPEAT;
                        hold_pulse <= 1'b1;
                        rep_cnt    <= '0;
                    end else if (hold_cnt != HLD_LAST) begin
                        hold_cnt <= hold_cnt + HLD_W'(1);
                    end
                end

                REPEAT: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (rep_cnt == REP_LAST) begin
                        hold_pulse <= 1'b1;
                        rep_cnt    <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end

                // btn_level stays 1 here. A release bounce returns to PRESSED
                // with the hold timer restarted and no strobe, even when the
                // button was already auto-repeating.
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state    <= PRESSED;
                        hold_cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer (ACTIVE_LOW=1, DEBOUNCE=4, HOLD=10,
// REPEAT=3). The stimulus process drives the pin and queues each strobe it
// expects as {kind, edge}. A separate monitor pops and compares the queue
// whenever any strobe is seen. Edge numbers come from a free-running posedge
// counter. A pin change driven on a negedge is first sampled on edge ecnt+1.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_HOLD    = 2;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic hold_pulse;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t expq[$];
    int  ecnt   = 0;
    int  checks = 0;
    int  errors = 0;

    button_debouncer #(
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3),
        .REPEAT_EN      (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold_pulse   (hold_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: compares every strobe the DUT presents with the queue head.
    always @(negedge clk) begin
        int   n;
        int   k;
        ev_t  e;
        n = int'(press_pulse) + int'(release_pulse) + int'(hold_pulse);
        if (n > 1) begin
            checks++;
            errors++;
            $display("FAIL multi_pulse: press=%b release=%b hold=%b at edge %0d, required at most one",
                     press_pulse, release_pulse, hold_pulse, ecnt);
        end else if (n == 1) begin
            k = press_pulse ? K_PRESS : (release_pulse ? K_RELEASE : K_HOLD);
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind %0d at edge %0d, required no pulse", k, ecnt);
            end else begin
                e = expq.pop_front();
                if (e.kind != k || e.at != ecnt) begin
                    errors++;
                    $display("FAIL pulse: got kind %0d at edge %0d, required kind %0d at edge %0d",
                             k, ecnt, e.kind, e.at);
                end
            end
        end
    end

    task automatic wait_to(input int e);
        while (ecnt < e) @(negedge clk);
    endtask

    task automatic push(input int k, input int t);
        ev_t e;
        e.kind = k;
        e.at   = t;
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b at edge %0d", nm, act, req, ecnt);
        end
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_level"}, btn_level, 1'b0);
        chk({nm, "_press"}, press_pulse, 1'b0);
        chk({nm, "_release"}, release_pulse, 1'b0);
        chk({nm, "_hold"}, hold_pulse, 1'b0);
    endtask

    // Any strobe still queued at this point never appeared.
    task automatic chk_drained(input string nm);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses missing (first kind %0d at edge %0d), required 0",
                     nm, expq.size(), expq[0].kind, expq[0].at);
            expq.delete();
        end
    endtask

    initial begin
        int t0;

        // 1. Reset state and quiet idle.
        rst     = 1'b1;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        rst = 1'b0;
        wait_to(ecnt + 20);
        chk_outs_zero("idle");
        chk_drained("idle_drain");

        // 2. Clean press for 12 cycles, then release.
        t0      = ecnt + 1;
        btn_raw = 1'b0;
        push(K_PRESS, t0 + 6);
        push(K_RELEASE, t0 + 18);
        wait_to(t0 + 5);
        chk("t2_level_pre", btn_level, 1'b0);
        wait_to(t0 + 6);
        chk("t2_level_on", btn_level, 1'b1);
        wait_to(t0 + 11);
        btn_raw = 1'b1;
        wait_to(t0 + 17);
        chk("t2_level_relwait", btn_level, 1'b1);
        wait_to(t0 + 18);
        chk("t2_level_off", btn_level, 1'b0);
        wait_to(t0 + 24);
        chk_drained("t2_drain");

        // 3. Press bounce: 3 pressed / 2 released, five times.
        for (int r = 0; r < 5; r++) begin
            btn_raw = 1'b0;
            wait_to(ecnt + 3);
            btn_raw = 1'b1;
            wait_to(ecnt + 2);
        end
        wait_to(ecnt + 10);
        chk("t3_level", btn_level, 1'b0);
        chk_drained("t3_drain");

        // 4. Long hold: press, first hold, auto-repeat, release.
        t0      = ecnt + 1;
        btn_raw = 1'b0;
        push(K_PRESS, t0 + 6);
        push(K_HOLD, t0 + 16);
        push(K_HOLD, t0 + 19);
        push(K_HOLD, t0 + 22);
        push(K_HOLD, t0 + 25);
        push(K_HOLD, t0 + 28);
        push(K_HOLD, t0 + 31);
        push(K_RELEASE, t0 + 36);
        wait_to(t0 + 20);
        chk("t4_level_held", btn_level, 1'b1);
        wait_to(t0 + 29);
        btn_raw = 1'b1;
        wait_to(t0 + 35);
        chk("t4_level_relwait", btn_level, 1'b1);
        wait_to(t0 + 36);
        chk("t4_level_off", btn_level, 1'b0);
        wait_to(t0 + 40);
        chk_drained("t4_drain");

        // 5. Release bounce restarts the hold timer without any strobe.
        t0      = ecnt + 1;
        btn_raw = 1'b0;
        push(K_PRESS, t0 + 6);
        push(K_HOLD, t0 + 24);
        push(K_HOLD, t0 + 27);
        push(K_HOLD, t0 + 30);
        push(K_RELEASE, t0 + 35);
        wait_to(t0 + 9);
        btn_raw = 1'b1;
        wait_to(t0 + 11);
        btn_raw = 1'b0;
        wait_to(t0 + 12);
        chk("t5_level_bounce_a", btn_level, 1'b1);
        wait_to(t0 + 13);
        chk("t5_level_bounce_b", btn_level, 1'b1);
        wait_to(t0 + 28);
        btn_raw = 1'b1;
        wait_to(t0 + 35);
        chk("t5_level_off", btn_level, 1'b0);
        wait_to(t0 + 40);
        chk_drained("t5_drain");

        // 6. Reset while held: outputs drop, fresh press after reset.
        t0      = ecnt + 1;
        btn_raw = 1'b0;
        push(K_PRESS, t0 + 6);
        push(K_HOLD, t0 + 16);
        push(K_PRESS, t0 + 26);
        push(K_RELEASE, t0 + 36);
        wait_to(t0 + 18);
        chk("t6_level_before_rst", btn_level, 1'b1);
        rst = 1'b1;
        #1;
        chk_outs_zero("t6_in_rst");
        wait_to(t0 + 19);
        chk_outs_zero("t6_rst_hold");
        rst = 1'b0;
        wait_to(t0 + 25);
        chk("t6_level_pre", btn_level, 1'b0);
        wait_to(t0 + 26);
        chk("t6_level_on", btn_level, 1'b1);
        wait_to(t0 + 29);
        btn_raw = 1'b1;
        wait_to(t0 + 40);
        chk("t6_level_off", btn_level, 1'b0);
        chk_drained("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
